// File: rtl/jtsdram_pkg.sv
// rtl/jtsdram_pkg.sv - shared state encoding, error width and fill pattern for the bank checker
package jtsdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int ERR_W = 8;

  // Fill pattern shared with the programming stage: low address word xor seed
  function automatic logic [15:0] pat_exp(input logic [15:0] a, input logic [15:0] r);
    return a ^ r;
  endfunction

endpackage

// File: rtl/jtsdram_tmo.sv
// rtl/jtsdram_tmo.sv - load/count/expire down-timer shared by gap and timeout phases
module jtsdram_tmo #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load wins over counting; the count parks at zero until reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/jtsdram_bank_chk.sv
// rtl/jtsdram_bank_chk.sv - per-bank read/verify sweep engine with optional interleaved rewrites
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int AW       = 22,
  parameter int LEN      = 256,
  parameter int SLOW_GAP = 3,
  parameter int TIMEOUT  = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       key,
  input  logic [15:0]      data_ref,
  input  logic             start,
  input  logic             slow,
  input  logic             we,
  output logic             done,
  output logic             bad,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    err_addr,
  output logic [AW-1:0]    addr,
  output logic             rd,
  output logic             wr,
  output logic [15:0]      din,
  input  logic             ack,
  input  logic             rdy,
  input  logic [15:0]      dout
);

  localparam int CW   = AW - 5;
  localparam int TMAX = (TIMEOUT > SLOW_GAP) ? TIMEOUT : SLOW_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  state_t         state;
  state_t         state_nx;
  state_t         st_after;
  logic [4:0]     key_l;
  logic [15:0]    ref_l;
  logic           slow_l;
  logic           we_l;
  logic [CW-1:0]  cnt;
  logic [15:0]    exp_v;
  logic           is_wr;
  logic           last;
  logic           hit;
  logic           tmo_hit;
  logic           mismatch;
  logic           log_err;
  logic           finish;
  logic           go_wait;
  logic           go_gap;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_en;
  logic           tmr_zero;

  assign addr  = {key_l, cnt};
  assign exp_v = pat_exp(addr[15:0], ref_l);
  assign is_wr = we_l & cnt[0];
  assign last  = (cnt == CW'(LEN - 1));

  // Access completion and error events; ack+rdy together in REQ completes without a WAIT dwell
  always_comb begin
    hit      = ((state == ST_REQ) && ack && rdy) || ((state == ST_WAIT) && rdy);
    tmo_hit  = (state == ST_WAIT) && !rdy && tmr_zero;
    mismatch = hit && !is_wr && (dout != exp_v);
    log_err  = mismatch || tmo_hit;
    finish   = (hit && last) || tmo_hit;
    go_wait  = (state == ST_REQ) && ack && !rdy;
    go_gap   = hit && !last && slow_l;
    tmr_load = go_wait || go_gap;
    tmr_val  = go_wait ? TW'(TIMEOUT - 1) : TW'(SLOW_GAP - 1);
    tmr_en   = (state == ST_WAIT) || (state == ST_GAP);
    st_after = last ? ST_IDLE : (slow_l ? ST_GAP : ST_REQ);
  end

  jtsdram_tmo #(.W(TW)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_REQ;
      ST_REQ: begin
        if (ack) state_nx = rdy ? st_after : ST_WAIT;
      end
      ST_WAIT: begin
        if (rdy) state_nx = st_after;
        else if (tmr_zero) state_nx = ST_IDLE;
      end
      ST_GAP: if (tmr_zero) state_nx = ST_REQ;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bank-port request outputs; requests vanish as soon as the state leaves REQ
  always_comb begin
    rd  = 1'b0;
    wr  = 1'b0;
    din = '0;
    if (state == ST_REQ) begin
      if (is_wr) begin
        wr  = 1'b1;
        din = exp_v;
      end else begin
        rd = 1'b1;
      end
    end
  end

  // Sweep context, word counter, completion and sticky error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_l    <= '0;
      ref_l    <= '0;
      slow_l   <= 1'b0;
      we_l     <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      bad      <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        key_l  <= key;
        ref_l  <= data_ref;
        slow_l <= slow;
        we_l   <= we;
        cnt    <= '0;
        done   <= 1'b0;
      end
      if (hit && !last) cnt <= cnt + 1'b1;
      if (finish) done <= 1'b1;
      if (log_err) begin
        bad      <= 1'b1;
        err_addr <= addr;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// tb/tb_jtsdram_bank_chk.sv - randomized controller model and scoreboard for the bank checker
module tb_jtsdram_bank_chk;

  localparam int AW       = 22;
  localparam int LEN      = 256;
  localparam int SLOW_GAP = 3;
  localparam int TIMEOUT  = 63;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    key = '0;
  logic [15:0]   data_ref = '0;
  logic          start = 1'b0;
  logic          slow = 1'b0;
  logic          we = 1'b0;
  logic          done;
  logic          bad;
  logic [7:0]    err_cnt;
  logic [AW-1:0] err_addr;
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [15:0]   din;
  logic          ack = 1'b0;
  logic          rdy = 1'b0;
  logic [15:0]   dout = '0;

  jtsdram_bank_chk #(.AW(AW), .LEN(LEN), .SLOW_GAP(SLOW_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .data_ref(data_ref), .start(start), .slow(slow),
    .we(we), .done(done), .bad(bad), .err_cnt(err_cnt), .err_addr(err_addr), .addr(addr),
    .rd(rd), .wr(wr), .din(din), .ack(ack), .rdy(rdy), .dout(dout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // sweep configuration
  logic [4:0]  c_key;
  logic [15:0] c_ref;
  bit c_slow, c_we, c_rnd, c_allbad;
  int c_wh, c_badi;

  // behavioural model of the observable outputs
  bit          mdone = 0, mbad = 0;
  int          merr = 0;
  logic [21:0] maddr = '0;

  // controller / sweep progress
  int tnow = 0, k = 0, due = 0, ackd = 0, rdyd = 0, w = 0, rst_hold = 3;
  bit busy = 0, acked = 0, seen = 0, start_pend = 0, rst_pend = 0;
  int n_rd, n_wr, n_acc, n_err, t_start, t_done;
  logic [21:0] first_addr, last_addr;
  logic [15:0] first_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  function automatic logic [21:0] acc_addr(input int kk);
    return 22'(int'(c_key) * 131072 + kk);
  endfunction

  function automatic logic [15:0] pat(input int kk);
    logic [21:0] a;
    a = acc_addr(kk);
    return a[15:0] ^ c_ref;
  endfunction

  task automatic log_err(input logic [21:0] a);
    mbad  = 1;
    maddr = a;
    if (merr < 255) merr++;
  endtask

  // controller returns data for access k and advances the sweep model
  task automatic complete();
    logic        is_w;
    logic [15:0] cor;
    is_w = c_we && k[0];
    if (is_w) begin
      dout = 16'($urandom);
    end else begin
      cor = '0;
      if (k == c_badi) cor = 16'h0008;
      else if (c_allbad) cor = 16'h8000;
      else if (c_rnd && $urandom_range(0, 15) == 0) cor = 16'(1) << $urandom_range(0, 15);
      dout = pat(k) ^ cor;
      if (cor != '0) begin
        log_err(acc_addr(k));
        n_err++;
      end
    end
    if (k == LEN - 1) begin
      busy = 0; acked = 0; mdone = 1; t_done = tnow;
    end else begin
      k++; acked = 0; seen = 0;
      due  = tnow + 1 + (c_slow ? SLOW_GAP : 0);
      ackd = c_rnd ? int'($urandom_range(0, 3)) : 0;
    end
  endtask

  // one negedge: compare outputs against the model, then drive the next controller response
  task automatic ctl();
    logic req, is_w;
    bit   b0;
    ack = 0; rdy = 0; start = 0; dout = 16'($urandom);
    if (!rst_n) begin
      if (rst_hold > 0) rst_hold--;
      if (rst_hold == 0) rst_n = 1;
      return;
    end
    chk("done", done, mdone);
    chk("bad", bad, mbad);
    chk("err_cnt", err_cnt, merr);
    chk("err_addr", err_addr, maddr);
    chk("rd_wr_excl", rd & wr, 0);
    req = rd | wr;
    b0  = busy;
    if (busy && !acked && tnow >= due) begin
      chk("req_present", req, 1);
      if (req) begin
        is_w = c_we && k[0];
        chk("addr", addr, acc_addr(k));
        chk("wr_type", wr, is_w);
        if (is_w) chk("din", din, pat(k));
        if (!seen) begin
          seen = 1; n_acc++;
          if (is_w) n_wr++; else n_rd++;
          if (k == 0) first_addr = addr;
          last_addr = addr;
          if (is_w && n_wr == 1) first_din = din;
        end
      end
    end else begin
      chk("req_idle", req, 0);
    end
    if (rst_pend && busy && acked && k >= 3) begin
      rst_n = 0;
      #1;
      chk("rst_rd", rd, 0);
      chk("rst_wr", wr, 0);
      chk("rst_done", done, 0);
      chk("rst_bad", bad, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_addr", err_addr, 0);
      rst_pend = 0; rst_hold = 3; busy = 0; acked = 0;
      mdone = 0; mbad = 0; merr = 0; maddr = '0;
      return;
    end
    if (busy && !acked && tnow >= due && req) begin
      if (ackd == 0) begin
        ack = 1; acked = 1; w = 0;
        rdyd = c_rnd ? int'($urandom_range(0, 4)) : 0;
        if (c_rnd && k != c_wh && $urandom_range(0, 3) == 0) begin
          rdy = 1;
          complete();
        end
      end else begin
        ackd--;
      end
    end else if (busy && acked) begin
      w++;
      if (k == c_wh) begin
        if (w == TIMEOUT) begin
          log_err(acc_addr(k));
          busy = 0; acked = 0; mdone = 1;
        end
      end else if (rdyd == 0) begin
        rdy = 1;
        complete();
      end else begin
        rdyd--;
      end
    end else if (c_rnd && (!busy || tnow + 1 < due)) begin
      rdy = ($urandom_range(0, 3) == 0);
    end
    if (b0 && c_rnd && $urandom_range(0, 31) == 0) start = 1;
    if (start_pend && !b0) begin
      start = 1; start_pend = 0; busy = 1; mdone = 0;
      k = 0; acked = 0; seen = 0; due = tnow + 1;
      ackd = c_rnd ? int'($urandom_range(0, 3)) : 0;
      t_start = tnow; n_rd = 0; n_wr = 0; n_acc = 0; n_err = 0;
    end
    key      = start ? c_key : 5'($urandom);
    data_ref = start ? c_ref : 16'($urandom);
    slow     = start ? c_slow : 1'($urandom);
    we       = start ? c_we : 1'($urandom);
  endtask

  task automatic tick();
    @(negedge clk);
    tnow++;
    ctl();
  endtask

  task automatic sweep(input logic [4:0] kk, input logic [15:0] rr, input bit sl, input bit wen,
                       input bit rn, input int wh, input int bi, input bit ab);
    c_key = kk; c_ref = rr; c_slow = sl; c_we = wen; c_rnd = rn;
    c_wh = wh; c_badi = bi; c_allbad = ab;
    start_pend = 1;
    for (int i = 0; i < 6000 && (start_pend || busy || !rst_n); i++) tick();
    if (start_pend || busy || !rst_n) begin
      n_tot++;
      $display("FAIL sweep_bound: sweep still running after 6000 cycles, required completion");
    end
    repeat (3) tick();
  endtask

  initial begin
    c_key = '0; c_ref = '0; c_slow = 0; c_we = 0; c_rnd = 0; c_wh = -1; c_badi = -1; c_allbad = 0;
    repeat (5) tick();
    chk("reset_done", done, 0);
    chk("reset_bad", bad, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_addr", addr, 0);
    chk("reset_rdwr", {rd, wr}, 0);
    chk("reset_din", din, 0);

    sweep(5'h0A, 16'hAAAA, 0, 0, 0, -1, -1, 0);
    chk("s1_nrd", n_rd, 256);
    chk("s1_nwr", n_wr, 0);
    chk("s1_first", first_addr, 22'h140000);
    chk("s1_last", last_addr, 22'h1400FF);
    chk("s1_done", done, 1);
    chk("s1_bad", bad, 0);
    chk("s1_cycles", t_done - t_start + 1, 513);

    sweep(5'h0A, 16'hAAAA, 0, 0, 0, -1, 17, 0);
    chk("s2_bad", bad, 1);
    chk("s2_err_cnt", err_cnt, 1);
    chk("s2_err_addr", err_addr, 22'h140011);
    chk("s2_nrd", n_rd, 256);

    sweep(5'h0A, 16'h1234, 0, 1, 0, -1, -1, 0);
    chk("s3_nrd", n_rd, 128);
    chk("s3_nwr", n_wr, 128);
    chk("s3_first_din", first_din, 16'h1235);
    chk("s3_err_cnt", err_cnt, 1);

    sweep(5'h0A, 16'hAAAA, 1, 0, 0, -1, -1, 0);
    chk("s4_cycles", t_done - t_start + 1, 1278);

    sweep(5'h0A, 16'hAAAA, 0, 0, 0, 5, -1, 0);
    chk("s5_err_cnt", err_cnt, 2);
    chk("s5_err_addr", err_addr, 22'h140005);
    chk("s5_done", done, 1);
    chk("s5_nacc", n_acc, 6);
    repeat (20) tick();

    sweep(5'h0A, 16'hAAAA, 0, 0, 1, -1, -1, 0);
    chk("s6_err_cnt", err_cnt, 2 + n_err);
    chk("s6_nacc", n_acc, 256);

    for (int r = 0; r < 4; r++) begin
      sweep(5'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, -1, -1, 0);
      chk("rand_nacc", n_acc, 256);
    end

    sweep(5'h1F, 16'h0F0F, 0, 0, 0, -1, -1, 1);
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_err_addr", err_addr, 22'h3E00FF);

    rst_pend = 1;
    sweep(5'h03, 16'h5555, 0, 1, 0, -1, -1, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_err_cnt", err_cnt, 0);

    sweep(5'h0A, 16'hAAAA, 0, 0, 0, -1, -1, 0);
    chk("fresh_done", done, 1);
    chk("fresh_bad", bad, 0);
    chk("fresh_err_cnt", err_cnt, 0);
    chk("fresh_nacc", n_acc, 256);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
